// File: rtl/adc_model_pkg.sv
//==============================================================================
// Module : adc_model_pkg
// Brief  : Shared constants, quarter-wave sine table and phase-step helper
//          for the serial SAR ADC sine model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package adc_model_pkg;

  localparam int SAMPLE_W   = 12;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int MIDSCALE   = 2048;
  localparam int QSIN_W     = 11;

  typedef logic [SAMPLE_W-1:0]   sample_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  // round(2047 * sin(pi/2 * i/64)), i = 0..64
  localparam logic [QSIN_W-1:0] QSIN [0:64] = '{
    11'd0,    11'd50,   11'd100,  11'd151,  11'd201,  11'd251,  11'd300,  11'd350,
    11'd399,  11'd449,  11'd497,  11'd546,  11'd594,  11'd642,  11'd690,  11'd737,
    11'd783,  11'd830,  11'd875,  11'd920,  11'd965,  11'd1009, 11'd1052, 11'd1095,
    11'd1137, 11'd1179, 11'd1219, 11'd1259, 11'd1299, 11'd1337, 11'd1375, 11'd1411,
    11'd1447, 11'd1483, 11'd1517, 11'd1550, 11'd1582, 11'd1614, 11'd1644, 11'd1674,
    11'd1702, 11'd1729, 11'd1756, 11'd1781, 11'd1805, 11'd1828, 11'd1850, 11'd1871,
    11'd1891, 11'd1910, 11'd1927, 11'd1944, 11'd1959, 11'd1973, 11'd1986, 11'd1997,
    11'd2008, 11'd2017, 11'd2025, 11'd2032, 11'd2037, 11'd2041, 11'd2045, 11'd2046,
    11'd2047
  };

  // Rounded 2^32 * 1e6 / (period_us * sclk_hz)
  function automatic logic [31:0] calc_phase_inc(input longint unsigned period_us,
                                                 input longint unsigned sclk_hz);
    longint unsigned den;
    den = period_us * sclk_hz;
    return 32'((64'd4294967296 * 64'd1000000 + den / 64'd2) / den);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_sine_lut.sv
//==============================================================================
// Module : adc_sine_lut
// Brief  : Combinational 8-bit phase index to 12-bit offset-binary sine sample
//          built from a quarter-wave table.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module adc_sine_lut
  import adc_model_pkg::*;
(
  input  logic [7:0]          idx_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  logic [1:0]        w_quad;
  logic [5:0]        w_off;
  logic [6:0]        w_tidx;
  logic [QSIN_W-1:0] w_mag;

  // Quadrants 1/3 read the table backwards; quadrants 2/3 fall below midscale
  always_comb begin
    w_quad   = idx_i[7:6];
    w_off    = idx_i[5:0];
    w_tidx   = w_quad[0] ? (7'd64 - {1'b0, w_off}) : {1'b0, w_off};
    w_mag    = QSIN[w_tidx];
    sample_o = w_quad[1] ? (SAMPLE_W'(MIDSCALE) - {1'b0, w_mag})
                         : (SAMPLE_W'(MIDSCALE) + {1'b0, w_mag});
  end

endmodule

`default_nettype wire

// File: rtl/adc_sine_model.sv
//==============================================================================
// Module : adc_sine_model
// Brief  : ADCS7476-style 12-bit serial ADC model sampling an internal sine;
//          all state moves on the falling edge of clk. Optional dither via
//          macro ADC_MODEL_NOISE_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module adc_sine_model
  import adc_model_pkg::*;
#(
  parameter int unsigned PERIOD    = 1000,
  parameter int unsigned SCLK_HZ   = 1000000,
  parameter logic [31:0] PHASE_INC = calc_phase_inc(64'(PERIOD), 64'(SCLK_HZ))
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic cs,
  output logic sd,
  output logic done
);

  logic [31:0]           phase_q, phase_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  frame_t                frame_q, frame_d;
  logic                  sd_q, sd_d;
  logic                  done_q, done_d;
  sample_t               w_sample;
  sample_t               w_load;

  adc_sine_lut u_lut (
    .idx_i    (phase_q[31:24]),
    .sample_o (w_sample)
  );

`ifdef ADC_MODEL_NOISE_EN
  logic [15:0]        lfsr_q, lfsr_d;
  logic signed [13:0] w_sum;

  // Advance once at the first bit of each frame so every frame sees fresh noise
  always_comb begin
    lfsr_d = lfsr_q;
    if (!cs && bit_cnt_q == 5'd0) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    w_sum = $signed({2'b00, w_sample}) + $signed({{10{lfsr_q[3]}}, lfsr_q[3:0]});
    if (w_sum < 14'sd0) begin
      w_load = '0;
    end else if (w_sum > 14'sd4095) begin
      w_load = '1;
    end else begin
      w_load = w_sum[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge reset or negedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign w_load = w_sample;
`endif

  always_comb begin
    phase_d   = run ? (phase_q + PHASE_INC) : phase_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    sd_d      = 1'b0;
    done_d    = 1'b0;
    if (cs) begin
      frame_d   = {{LEAD_ZEROS{1'b0}}, w_load};
      bit_cnt_d = '0;
    end else if (bit_cnt_q < 5'(FRAME_BITS)) begin
      sd_d      = frame_q[FRAME_BITS-1];
      frame_d   = {frame_q[FRAME_BITS-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 5'd1;
      done_d    = (bit_cnt_q == 5'(FRAME_BITS - 1));
    end
  end

  always_ff @(posedge reset or negedge clk) begin
    if (reset) begin
      phase_q   <= '0;
      bit_cnt_q <= '0;
      frame_q   <= 16'h0800;
      sd_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      sd_q      <= sd_d;
      done_q    <= done_d;
    end
  end

  assign sd   = sd_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_sine_model.sv
//==============================================================================
// Module : tb_adc_sine_model
// Brief  : Directed self-checking bench for adc_sine_model at default
//          parameters (PHASE_INC = 4294967).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_adc_sine_model;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic cs;
  logic sd;
  logic done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] bits;
  int          dcnt;
  int          dpos;

  adc_sine_model u_dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .cs    (cs),
    .sd    (sd),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame words are exact for the clean sine, within -8..+7 with dither
  task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
`ifdef ADC_MODEL_NOISE_EN
    int lo;
    int hi;
    lo = (int'(exp) > 8) ? int'(exp) - 8 : 0;
    hi = (int'(exp) + 7 > 4095) ? 4095 : int'(exp) + 7;
    chk(tag, {31'd0, (int'(obs) >= lo) && (int'(obs) <= hi)}, 32'd1);
`else
    chk(tag, {16'd0, obs}, {16'd0, exp});
`endif
  endtask

  // Inputs change just after the rising edge; DUT acts on the falling edge
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    cs  = 1'b1;
    run = r;
    repeat (n) cyc();
  endtask

  task automatic frame(input int n, input logic r,
                       output logic [31:0] b, output int dc, output int dp);
    cs  = 1'b0;
    run = r;
    b   = '0;
    dc  = 0;
    dp  = 0;
    for (int i = 1; i <= n; i++) begin
      cyc();
      b = {b[30:0], sd};
      if (done) begin
        dc++;
        dp = i;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    cs    = 1'b1;
    run   = 1'b0;
    repeat (2) cyc();
    chk("reset_sd",   {31'd0, sd},   32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Phase 0 -> midscale
    idle(2, 1'b0);
    frame(16, 1'b0, bits, dcnt, dpos);
    chk_word("first_word", bits[15:0], 16'h0800);
    chk("first_done_cnt", dcnt, 1);
    chk("first_done_pos", dpos, 16);

    // Last load sees phase = 251*INC -> idx 64
    idle(252, 1'b1);
    frame(16, 1'b0, bits, dcnt, dpos);
    chk_word("peak_word", bits[15:0], 16'h0FFF);
    chk("peak_done_cnt", dcnt, 1);

    // Last load sees phase = 751*INC -> idx 192
    idle(500, 1'b1);
    frame(16, 1'b0, bits, dcnt, dpos);
    chk_word("trough_word", bits[15:0], 16'h0001);

    // Held phase (752*INC, still idx 192)
    idle(500, 1'b0);
    frame(16, 1'b0, bits, dcnt, dpos);
    chk_word("hold_word", bits[15:0], 16'h0001);

    // Last load sees phase = 1001*INC -> wraps to idx 0
    idle(250, 1'b1);
    frame(7, 1'b1, bits, dcnt, dpos);
`ifdef ADC_MODEL_NOISE_EN
    chk("abort_bits", {28'd0, bits[6:3]}, 32'd0);
`else
    chk("abort_bits", {25'd0, bits[6:0]}, 32'h04);
`endif
    chk("abort_no_done", dcnt, 0);

    // Last load sees phase = 1251*INC -> second-lap idx 64
    idle(243, 1'b1);
    frame(16, 1'b0, bits, dcnt, dpos);
    chk_word("after_abort_word", bits[15:0], 16'h0FFF);
    chk("after_abort_done_cnt", dcnt, 1);

    // Overrun: 24 clocks with cs low
    idle(1, 1'b0);
    frame(24, 1'b0, bits, dcnt, dpos);
    chk_word("overrun_word", bits[23:8], 16'h0FFF);
    chk("overrun_tail", {24'd0, bits[7:0]}, 32'd0);
    chk("overrun_done_cnt", dcnt, 1);
    chk("overrun_done_pos", dpos, 16);

    // Reset between clock edges, after bit 9 has been driven
    idle(1, 1'b0);
    frame(9, 1'b0, bits, dcnt, dpos);
    chk("pre_reset_bits", {23'd0, bits[8:0]}, 32'h01F);
    chk("pre_reset_sd", {31'd0, sd}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_sd",   {31'd0, sd},   32'd0);
    chk("async_reset_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    repeat (2) cyc();
    reset = 1'b0;
    idle(1, 1'b0);
    frame(16, 1'b0, bits, dcnt, dpos);
    chk_word("post_reset_word", bits[15:0], 16'h0800);
    chk("post_reset_done_cnt", dcnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
